// File: rtl/winograd_pkg.sv
// Shared constants, transform coefficient tables and width helpers for the
// Winograd F(2x2,3x3) processing element.
package winograd_pkg;

  localparam int TILE  = 4;
  localparam int K     = 3;
  localparam int M_OUT = 2;

  typedef enum logic [1:0] {
    XF_BT,
    XF_G,
    XF_AT
  } xform_mode_e;

  // Pipeline tags carried alongside every stage's data.
  typedef struct packed {
    logic vld;
    logic last;
    logic first;
  } beat_tag_t;

  // G' = 2G keeps every kernel transform integer; A^T rows 2..3 are unused padding.
  localparam int BT_TAB [4][4] = '{'{1, 0, -1, 0}, '{0, 1, 1, 0}, '{0, -1, 1, 0}, '{0, 1, 0, -1}};
  localparam int G_TAB  [4][4] = '{'{2, 0, 0, 0}, '{1, 1, 1, 0}, '{1, -1, 1, 0}, '{0, 0, 2, 0}};
  localparam int AT_TAB [4][4] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};

  function automatic int xf_coef(xform_mode_e mode, int i, int k);
    case (mode)
      XF_BT:   return BT_TAB[i][k];
      XF_G:    return G_TAB[i][k];
      default: return AT_TAB[i][k];
    endcase
  endfunction

  function automatic int v_width(int dw);
    return dw + 2;
  endfunction

  function automatic int u_width(int kw);
    return kw + 4;
  endfunction

  function automatic int m_width(int dw, int kw);
    return dw + kw + 6;
  endfunction

  function automatic int y_width(int dw, int kw);
    return dw + kw + 10;
  endfunction

  function automatic int out_width(int dw, int kw, int ch_bits);
    return dw + kw + 8 + ch_bits;
  endfunction

endpackage

// File: rtl/wino_xform_4pt.sv
// Combinational 1-D 4-point Winograd transform, y = T * x, with T chosen by MODE.
// Inputs are sign-extended to OUT_W before any arithmetic.
module wino_xform_4pt
  import winograd_pkg::*;
#(
  parameter xform_mode_e MODE  = XF_BT,
  parameter int          IN_W  = 8,
  parameter int          OUT_W = 10
) (
  input  logic [TILE-1:0][IN_W-1:0]  x,
  output logic [TILE-1:0][OUT_W-1:0] y
);

  logic signed [OUT_W-1:0] sum;
  logic signed [OUT_W-1:0] xe;

  // Coefficients are only 0, +-1 and 2, so adds and a shift replace multipliers.
  always_comb begin
    y   = '0;
    sum = '0;
    xe  = '0;
    for (int i = 0; i < TILE; i++) begin
      sum = '0;
      for (int k = 0; k < TILE; k++) begin
        xe = OUT_W'($signed(x[k]));
        case (xf_coef(MODE, i, k))
          1:       sum = sum + xe;
          -1:      sum = sum - xe;
          2:       sum = sum + (xe <<< 1);
          default: ;
        endcase
      end
      y[i] = sum;
    end
  end

endmodule

// File: rtl/winograd_pe_acc.sv
// Winograd F(2x2,3x3) PE: 5-stage transform pipeline plus a channel-group
// accumulator. Handshake: a beat moves when valid && ready; one global enable stalls everything.
module winograd_pe_acc
  import winograd_pkg::*;
#(
  parameter int  DATA_W       = 8,
  parameter int  KERNEL_W     = 8,
  parameter int  MAX_CHANNELS = 16,
  localparam int CH_BITS      = $clog2(MAX_CHANNELS),
  localparam int OUT_W        = out_width(DATA_W, KERNEL_W, CH_BITS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [16*DATA_W-1:0]   in_data,
  input  logic [9*KERNEL_W-1:0]  in_kernel,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*OUT_W-1:0]     out_data,
  output logic [CH_BITS:0]       ch_count,
  output logic                   ovf_err
);

  localparam int V_W   = v_width(DATA_W);
  localparam int U_W   = u_width(KERNEL_W);
  localparam int M_W   = m_width(DATA_W, KERNEL_W);
  localparam int Y_W   = y_width(DATA_W, KERNEL_W);
  localparam int ACC_W = OUT_W + 2;
  localparam logic [CH_BITS:0] CH_MAX = (CH_BITS + 1)'(MAX_CHANNELS);

  logic en;
  logic accept;

  beat_tag_t s1_tag_d, s1_tag_q, s2_tag_d, s2_tag_q, s3_tag_d, s3_tag_q;
  beat_tag_t s4_tag_d, s4_tag_q, s5_tag_d, s5_tag_q;

  logic [TILE-1:0][TILE-1:0][V_W-1:0]  s1_v_c, s1_v_d, s1_v_q;
  logic [TILE-1:0][K-1:0][U_W-1:0]     s1_g_c, s1_g_d, s1_g_q;
  logic [TILE-1:0][TILE-1:0][V_W-1:0]  s2_v_c, s2_v_d, s2_v_q;
  logic [TILE-1:0][TILE-1:0][U_W-1:0]  s2_u_c, s2_u_d, s2_u_q;
  logic [TILE-1:0][TILE-1:0][M_W-1:0]  m_c, m_d, m_q;
  logic [M_OUT-1:0][TILE-1:0][Y_W-1:0] p_c, p_d, p_q;
  logic [M_OUT-1:0][M_OUT-1:0][Y_W-1:0] y_c, y_d, y_q;
  logic [M_OUT-1:0][M_OUT-1:0][ACC_W-1:0] acc_sum, acc_d, acc_q;

  logic [4*OUT_W-1:0] out_data_d, out_data_q;
  logic               out_valid_d, out_valid_q;
  logic [CH_BITS:0]   ch_count_d, ch_count_q;
  logic               ovf_err_d, ovf_err_q;
  logic               grp_open_d, grp_open_q;

  // S1: B^T d and G' g act on columns of the raw tile/kernel.
  for (genvar j = 0; j < TILE; j++) begin : g_s1_data
    logic [TILE-1:0][DATA_W-1:0] col;
    logic [TILE-1:0][V_W-1:0]    res;
    for (genvar k = 0; k < TILE; k++) begin : g_k
      assign col[k]       = in_data[(k*TILE+j)*DATA_W +: DATA_W];
      assign s1_v_c[k][j] = res[k];
    end
    wino_xform_4pt #(.MODE(XF_BT), .IN_W(DATA_W), .OUT_W(V_W)) u_xf (.x(col), .y(res));
  end

  for (genvar j = 0; j < K; j++) begin : g_s1_kern
    logic [TILE-1:0][KERNEL_W-1:0] col;
    logic [TILE-1:0][U_W-1:0]      res;
    for (genvar k = 0; k < TILE; k++) begin : g_k
      if (k < K) begin : g_tap
        assign col[k] = in_kernel[(k*K+j)*KERNEL_W +: KERNEL_W];
      end else begin : g_pad
        assign col[k] = '0;
      end
      assign s1_g_c[k][j] = res[k];
    end
    wino_xform_4pt #(.MODE(XF_G), .IN_W(KERNEL_W), .OUT_W(U_W)) u_xf (.x(col), .y(res));
  end

  // S2: right-multiply by B and G'^T, one row at a time.
  for (genvar i = 0; i < TILE; i++) begin : g_s2
    wino_xform_4pt #(.MODE(XF_BT), .IN_W(V_W), .OUT_W(V_W)) u_xf_v (
      .x(s1_v_q[i]), .y(s2_v_c[i]));
    wino_xform_4pt #(.MODE(XF_G), .IN_W(U_W), .OUT_W(U_W)) u_xf_u (
      .x({{U_W{1'b0}}, s1_g_q[i]}), .y(s2_u_c[i]));
  end

  always_comb begin
    m_c = '0;
    for (int i = 0; i < TILE; i++) begin
      for (int j = 0; j < TILE; j++) begin
        m_c[i][j] = M_W'($signed(s2_v_q[i][j])) * M_W'($signed(s2_u_q[i][j]));
      end
    end
  end

  // S4: A^T M on columns; only the first M_OUT outputs of A^T are meaningful.
  for (genvar j = 0; j < TILE; j++) begin : g_s4
    logic [TILE-1:0][M_W-1:0] col;
    logic [TILE-1:0][Y_W-1:0] res;
    logic                     unused_rows;
    for (genvar k = 0; k < TILE; k++) begin : g_k
      assign col[k] = m_q[k][j];
    end
    for (genvar i = 0; i < M_OUT; i++) begin : g_i
      assign p_c[i][j] = res[i];
    end
    assign unused_rows = ^res[TILE-1:M_OUT];
    wino_xform_4pt #(.MODE(XF_AT), .IN_W(M_W), .OUT_W(Y_W)) u_xf (.x(col), .y(res));
  end

  for (genvar i = 0; i < M_OUT; i++) begin : g_s5
    logic [TILE-1:0][Y_W-1:0] res;
    logic                     unused_cols;
    wino_xform_4pt #(.MODE(XF_AT), .IN_W(Y_W), .OUT_W(Y_W)) u_xf (.x(p_q[i]), .y(res));
    assign y_c[i]      = res[M_OUT-1:0];
    assign unused_cols = ^res[TILE-1:M_OUT];
  end

  assign en     = !(out_valid_q && !out_ready);
  assign accept = in_valid && en;

  always_comb begin
    s1_tag_d    = s1_tag_q;
    s2_tag_d    = s2_tag_q;
    s3_tag_d    = s3_tag_q;
    s4_tag_d    = s4_tag_q;
    s5_tag_d    = s5_tag_q;
    s1_v_d      = s1_v_q;
    s1_g_d      = s1_g_q;
    s2_v_d      = s2_v_q;
    s2_u_d      = s2_u_q;
    m_d         = m_q;
    p_d         = p_q;
    y_d         = y_q;
    acc_sum     = '0;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ch_count_d  = ch_count_q;
    ovf_err_d   = ovf_err_q;
    grp_open_d  = grp_open_q;

    if (en) begin
      s1_tag_d.vld   = accept;
      s1_tag_d.last  = in_last;
      s1_tag_d.first = !grp_open_q;
      s1_v_d         = s1_v_c;
      s1_g_d         = s1_g_c;
      s2_tag_d       = s1_tag_q;
      s2_v_d         = s2_v_c;
      s2_u_d         = s2_u_c;
      s3_tag_d       = s2_tag_q;
      m_d            = m_c;
      s4_tag_d       = s3_tag_q;
      p_d            = p_c;
      s5_tag_d       = s4_tag_q;
      y_d            = y_c;
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Y carries a factor of 4 from G' = 2G; the >>>2 on output is exact.
    if (en && s5_tag_q.vld) begin
      for (int i = 0; i < M_OUT; i++) begin
        for (int j = 0; j < M_OUT; j++) begin
          acc_sum[i][j] = (s5_tag_q.first ? '0 : acc_q[i][j]) + ACC_W'($signed(y_q[i][j]));
          out_data_d[(i*M_OUT+j)*OUT_W +: OUT_W] =
            s5_tag_q.last ? acc_sum[i][j][OUT_W+1:2] : out_data_q[(i*M_OUT+j)*OUT_W +: OUT_W];
        end
      end
      if (s5_tag_q.last) begin
        acc_d       = '0;
        out_valid_d = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
    end

    if (accept) begin
      ch_count_d = in_last ? '0 : ch_count_q + 1'b1;
      grp_open_d = !in_last;
      if (!in_last && (ch_count_q == CH_MAX)) begin
        ovf_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_tag_q    <= '0;
      s2_tag_q    <= '0;
      s3_tag_q    <= '0;
      s4_tag_q    <= '0;
      s5_tag_q    <= '0;
      s1_v_q      <= '0;
      s1_g_q      <= '0;
      s2_v_q      <= '0;
      s2_u_q      <= '0;
      m_q         <= '0;
      p_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ch_count_q  <= '0;
      ovf_err_q   <= 1'b0;
      grp_open_q  <= 1'b0;
    end else begin
      s1_tag_q    <= s1_tag_d;
      s2_tag_q    <= s2_tag_d;
      s3_tag_q    <= s3_tag_d;
      s4_tag_q    <= s4_tag_d;
      s5_tag_q    <= s5_tag_d;
      s1_v_q      <= s1_v_d;
      s1_g_q      <= s1_g_d;
      s2_v_q      <= s2_v_d;
      s2_u_q      <= s2_u_d;
      m_q         <= m_d;
      p_q         <= p_d;
      y_q         <= y_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ch_count_q  <= ch_count_d;
      ovf_err_q   <= ovf_err_d;
      grp_open_q  <= grp_open_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign ch_count  = ch_count_q;
  assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_winograd_pe_acc.sv
// Directed bench for winograd_pe_acc: hand-computed group results in an
// expected queue, checked in order whenever an output handshake occurs.
module tb_winograd_pe_acc;

  localparam int DATA_W       = 8;
  localparam int KERNEL_W     = 8;
  localparam int MAX_CHANNELS = 16;
  localparam int CH_BITS      = 4;
  localparam int OUT_W        = 28;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [16*DATA_W-1:0]  in_data = '0;
  logic [9*KERNEL_W-1:0] in_kernel = '0;
  logic                  in_last = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [4*OUT_W-1:0]    out_data;
  logic [CH_BITS:0]      ch_count;
  logic                  ovf_err;

  int checks = 0;
  int failures = 0;
  logic [4*OUT_W-1:0] exp_q[$];
  logic [4*OUT_W-1:0] exp_v;

  winograd_pe_acc #(
    .DATA_W(DATA_W), .KERNEL_W(KERNEL_W), .MAX_CHANNELS(MAX_CHANNELS)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_kernel(in_kernel), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ch_count(ch_count), .ovf_err(ovf_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_val);
    checks++;
    assert (obs === exp_val) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_val);
    end
  endtask

  function automatic logic [16*DATA_W-1:0] tile_ramp();
    logic [16*DATA_W-1:0] t;
    for (int e = 0; e < 16; e++) t[e*DATA_W +: DATA_W] = DATA_W'(e);
    return t;
  endfunction

  function automatic logic [16*DATA_W-1:0] tile_const(input logic [DATA_W-1:0] v);
    logic [16*DATA_W-1:0] t;
    for (int e = 0; e < 16; e++) t[e*DATA_W +: DATA_W] = v;
    return t;
  endfunction

  function automatic logic [9*KERNEL_W-1:0] kern_const(input logic [KERNEL_W-1:0] v);
    logic [9*KERNEL_W-1:0] g;
    for (int e = 0; e < 9; e++) g[e*KERNEL_W +: KERNEL_W] = v;
    return g;
  endfunction

  function automatic logic [9*KERNEL_W-1:0] kern_center();
    logic [9*KERNEL_W-1:0] g;
    g = '0;
    g[4*KERNEL_W +: KERNEL_W] = KERNEL_W'(1);
    return g;
  endfunction

  function automatic logic [4*OUT_W-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [4*OUT_W-1:0] v;
    v[0*OUT_W +: OUT_W] = OUT_W'(a);
    v[1*OUT_W +: OUT_W] = OUT_W'(b);
    v[2*OUT_W +: OUT_W] = OUT_W'(c);
    v[3*OUT_W +: OUT_W] = OUT_W'(d);
    return v;
  endfunction

  // driver tasks
  task automatic send(input logic [16*DATA_W-1:0] d, input logic [9*KERNEL_W-1:0] g, input logic last);
    int guard = 0;
    in_data   = d;
    in_kernel = g;
    in_last   = last;
    in_valid  = 1'b1;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $error("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // scoreboard: outputs sampled mid-cycle, one per handshake
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_out observed=%0h expected=none", out_data);
      end else begin
        exp_v = exp_q.pop_front();
        for (int e = 0; e < 4; e++) begin
          chk($sformatf("out_e%0d", e), $signed(out_data[e*OUT_W +: OUT_W]),
              $signed(exp_v[e*OUT_W +: OUT_W]));
        end
      end
    end
  end

  initial begin
    int guard;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", (out_data === '0) ? 0 : 1, 0);
    chk("rst_ch_count", ch_count, 0);
    chk("rst_ovf_err", ovf_err, 0);

    // identity kernel, single beat, exact latency
    exp_q.push_back(pack4(5, 6, 9, 10));
    send(tile_ramp(), kern_center(), 1'b1);
    chk("id_ch_count", ch_count, 0);
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      chk($sformatf("id_lat_edge%0d", e), out_valid, (e == 5) ? 1 : 0);
    end
    drain();

    // multi-channel all-ones, 4 beats
    exp_q.push_back(pack4(36, 36, 36, 36));
    for (int b = 0; b < 4; b++) begin
      send(tile_const(8'd1), kern_const(8'd1), b == 3);
      chk($sformatf("mc_ch_count_b%0d", b), ch_count, (b == 3) ? 0 : b + 1);
    end
    drain();

    // sign/width extremes
    exp_q.push_back(pack4(-146304, -146304, -146304, -146304));
    send(tile_const(8'd127), kern_const(8'h80), 1'b1);
    drain();
    exp_q.push_back(pack4(-2340864, -2340864, -2340864, -2340864));
    for (int b = 0; b < 16; b++) send(tile_const(8'd127), kern_const(8'h80), b == 15);
    drain();
    chk("ext16_ovf_err", ovf_err, 0);

    // backpressure with three back-to-back single-beat groups
    out_ready = 1'b0;
    exp_q.push_back(pack4(5, 6, 9, 10));
    exp_q.push_back(pack4(9, 9, 9, 9));
    exp_q.push_back(pack4(-146304, -146304, -146304, -146304));
    send(tile_ramp(), kern_center(), 1'b1);
    send(tile_const(8'd1), kern_const(8'd1), 1'b1);
    send(tile_const(8'd127), kern_const(8'h80), 1'b1);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("bp_out_valid", out_valid, 1);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_in_ready_c%0d", c), in_ready, 0);
      @(posedge clk); #1;
    end
    chk("bp_held_count", exp_q.size(), 3);
    out_ready = 1'b1;
    drain();

    // reset mid-group, then a clean identity group
    send(tile_const(8'd1), kern_const(8'd1), 1'b0);
    send(tile_const(8'd1), kern_const(8'd1), 1'b0);
    chk("mid_ch_count_pre", ch_count, 2);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_ch_count_post", ch_count, 0);
    chk("mid_out_valid_post", out_valid, 0);
    exp_q.push_back(pack4(5, 6, 9, 10));
    send(tile_ramp(), kern_center(), 1'b1);
    drain();

    // overflow: 17 beats without last
    for (int b = 0; b < 17; b++) begin
      send(tile_const(8'd1), kern_const(8'd1), 1'b0);
      if (b == 15) chk("ovf_after16", ovf_err, 0);
    end
    chk("ovf_after17", ovf_err, 1);
    chk("ovf_ch_count", ch_count, 17);
    repeat (8) @(posedge clk);
    #1;
    chk("ovf_sticky", ovf_err, 1);
    chk("ovf_no_output", out_valid, 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
